echo_timer: RTL and testbench

//  Downstream consumer of the active-low trigger pulse train (pulse_out) from the

---
 rtl/echo_timer.sv | 193 +++++++++++++++++++
 tb/tb_echo_timer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_timer.sv
// Echo pulse-width timer: measures echo_in high time in us after each active-low trigger; valid/ready result.
// Optional macro ECHO_TIMER_TRIG_CHECK_EN enables minimum trigger-width checking (trig_short).
module echo_timer #(
  parameter int CLK_MHZ      = 24,
  parameter int T_US_TIMEOUT = 30_000,
  parameter int US_WIDTH     = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int TRIG_MIN_US  = 10
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                trig_n,
  input  logic                echo_in,
  input  logic                result_ready,
  output logic                result_valid,
  output logic [US_WIDTH-1:0] echo_us,
  output logic                timeout,
  output logic                overrun,
  output logic                busy,
  output logic                trig_short
);

  localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int TW = $clog2(T_US_TIMEOUT + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_MHZ - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(T_US_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   echo_prev_q;
  logic                   trig_prev_q;
  logic [PW-1:0]          presc_q, presc_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [US_WIDTH-1:0]    us_q, us_d;
  logic [US_WIDTH-1:0]    echo_us_q, echo_us_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;

  logic echo_s, echo_rise, echo_fall, trig_rise, trig_fall, tick;

  assign echo_s    = sync_q[SYNC_STAGES-1];
  assign echo_rise = echo_s & ~echo_prev_q;
  assign echo_fall = ~echo_s & echo_prev_q;
  assign trig_fall = trig_prev_q & ~trig_n;
  assign trig_rise = ~trig_prev_q & trig_n;
  assign tick      = (presc_q == PRESC_MAX);

`ifdef ECHO_TIMER_TRIG_CHECK_EN
  localparam int MW = $clog2(TRIG_MIN_US + 1);
  localparam logic [MW-1:0] TRIG_MIN = MW'(TRIG_MIN_US);
  logic [MW-1:0] trig_us_q, trig_us_d;
  logic          trig_short_q, trig_short_d;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      echo_prev_q <= 1'b0;
      // Idle level of the trigger, so reset release never looks like a fall.
      trig_prev_q <= 1'b1;
      presc_q     <= '0;
      tmo_q       <= '0;
      us_q        <= '0;
      echo_us_q   <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], echo_in};
      echo_prev_q <= echo_s;
      trig_prev_q <= trig_n;
      presc_q     <= presc_d;
      tmo_q       <= tmo_d;
      us_q        <= us_d;
      echo_us_q   <= echo_us_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef ECHO_TIMER_TRIG_CHECK_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      trig_us_q    <= '0;
      trig_short_q <= 1'b0;
    end else begin
      trig_us_q    <= trig_us_d;
      trig_short_q <= trig_short_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    tmo_d     = tmo_q;
    us_d      = us_q;
    echo_us_d = echo_us_q;
    timeout_d = timeout_q;
    overrun_d = trig_fall && (state_q != IDLE);
`ifdef ECHO_TIMER_TRIG_CHECK_EN
    trig_us_d    = trig_us_q;
    trig_short_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (trig_fall) begin
          state_d = ARM;
`ifdef ECHO_TIMER_TRIG_CHECK_EN
          trig_us_d = '0;
          presc_d   = '0;
`endif
        end
      end
      ARM: begin
`ifdef ECHO_TIMER_TRIG_CHECK_EN
        if (tick && (trig_us_q < TRIG_MIN)) trig_us_d = trig_us_q + 1'b1;
        if (trig_rise && (trig_us_q < TRIG_MIN)) begin
          state_d      = IDLE;
          trig_short_d = 1'b1;
        end else if (trig_rise) begin
          state_d = WAIT_ECHO;
          tmo_d   = '0;
          presc_d = '0;
        end
`else
        if (trig_rise) begin
          state_d = WAIT_ECHO;
          tmo_d   = '0;
          presc_d = '0;
        end
`endif
      end
      WAIT_ECHO: begin
        if (tick) tmo_d = tmo_q + 1'b1;
        if (tmo_q == TMO_MAX) begin
          state_d   = HOLD;
          timeout_d = 1'b1;
          echo_us_d = '1;
        end else if (echo_rise) begin
          state_d = MEASURE;
          us_d    = '0;
          presc_d = '0;
        end
      end
      MEASURE: begin
        if (tick) begin
          tmo_d = tmo_q + 1'b1;
          if (us_q != '1) us_d = us_q + 1'b1;
        end
        // A completed echo takes priority over a simultaneous timeout.
        if (echo_fall) begin
          state_d   = HOLD;
          echo_us_d = us_q;
          timeout_d = 1'b0;
        end else if (tmo_q == TMO_MAX) begin
          state_d   = HOLD;
          timeout_d = 1'b1;
          echo_us_d = '1;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d   = IDLE;
          echo_us_d = '0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign echo_us      = echo_us_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;
`ifdef ECHO_TIMER_TRIG_CHECK_EN
  assign trig_short   = trig_short_q;
`else
  assign trig_short   = 1'b0;
`endif

endmodule

// File: tb/tb_echo_timer.sv
// Randomized scoreboard bench for echo_timer; expectations come from pulse timings in microseconds.
// Honours ECHO_TIMER_TRIG_CHECK_EN for the short-trigger scenario.
module tb_echo_timer;
  localparam int CLK   = 4;
  localparam int T_TMO = 300;
  localparam int USW   = 8;
  localparam int MAXUS = (1 << USW) - 1;

  logic           sys_clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic           trig_n = 1'b1;
  logic           echo_in = 1'b0;
  logic           result_ready = 1'b0;
  logic           result_valid, timeout, overrun, busy, trig_short;
  logic [USW-1:0] echo_us;

  echo_timer #(
    .CLK_MHZ(CLK), .T_US_TIMEOUT(T_TMO), .US_WIDTH(USW), .SYNC_STAGES(2), .TRIG_MIN_US(10)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .trig_n(trig_n), .echo_in(echo_in),
    .result_ready(result_ready), .result_valid(result_valid), .echo_us(echo_us),
    .timeout(timeout), .overrun(overrun), .busy(busy), .trig_short(trig_short)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {bit to; int us; int tol;} exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int accepted = 0, n_exp = 0;
  int ovr_cnt = 0, ovr_exp = 0, short_cnt = 0, short_exp = 0;
  bit hold_ready = 1'b0;

  bit in_hold = 0, stable = 0, drop_pending = 0, prev_ovr = 0, prev_short = 0;
  logic [USW-1:0] held_us;
  logic held_to;

  // Monitor: pops one expectation per accepted result.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      in_hold = 0; drop_pending = 0; prev_ovr = 0; prev_short = 0;
    end else begin
      if (drop_pending) begin
        checks++;
        if (result_valid) begin
          failures++;
          $display("FAIL valid_drop: result_valid=%0b after accept, required 0", result_valid);
        end
        drop_pending = 0;
      end else if (result_valid) begin
        if (!in_hold) begin
          in_hold = 1; stable = 1; held_us = echo_us; held_to = timeout;
        end else if (echo_us !== held_us || timeout !== held_to) begin
          stable = 0;
        end
        if (result_ready) begin
          exp_t e;
          int diff;
          in_hold = 0; drop_pending = 1; accepted++;
          checks++;
          if (!stable) begin
            failures++;
            $display("FAIL hold_stable: result changed while waiting, now us=%0d to=%0b", echo_us, timeout);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: us=%0d to=%0b, required no result", echo_us, timeout);
          end else begin
            e = exp_q.pop_front();
            diff = int'(echo_us) - e.us;
            if (diff < 0) diff = -diff;
            if (timeout !== e.to || diff > e.tol) begin
              failures++;
              $display("FAIL result: us=%0d to=%0b, required us=%0d(+/-%0d) to=%0b",
                       echo_us, timeout, e.us, e.tol, e.to);
            end
          end
        end
      end
      if (overrun) begin
        ovr_cnt++;
        checks++;
        if (prev_ovr) begin
          failures++;
          $display("FAIL overrun_width: overrun high 2 cycles, required 1");
        end
      end
      if (trig_short) begin
        short_cnt++;
        checks++;
        if (prev_short) begin
          failures++;
          $display("FAIL trig_short_width: high 2 cycles, required 1");
        end
      end
      prev_ovr = overrun; prev_short = trig_short;
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk); #1;
      result_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_us(input int n);
    repeat (n * CLK) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_accepts(input int n);
    int cnt = 0;
    while (accepted < n && cnt < 4000) begin
      @(posedge sys_clk); cnt++;
    end
    #1;
    checks++;
    if (accepted < n) begin
      failures++;
      $display("FAIL accept_wait: accepted=%0d, required %0d", accepted, n);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({result_valid, echo_us, timeout, overrun, busy, trig_short} !== '0) begin
      failures++;
      $display("FAIL %s: valid=%0b us=%0d to=%0b ovr=%0b busy=%0b short=%0b, required all 0",
               name, result_valid, echo_us, timeout, overrun, busy, trig_short);
    end
  endtask

  // d<0: echo already high before release; w==0: no echo at all.
  task automatic push_txn(input int l, input int d, input int w);
    exp_t e;
    if (w == 0 || d < 0 || d + w >= T_TMO) begin
      e.to = 1; e.us = MAXUS; e.tol = 0;
    end else begin
      e.to = 0;
      e.us = (w > MAXUS) ? MAXUS : w;
      e.tol = (w > MAXUS) ? 0 : 1;
    end
    exp_q.push_back(e); n_exp++;
    trig_n = 1'b0;
    if (d < 0) echo_in = 1'b1;
    wait_us(l);
    trig_n = 1'b1;
    if (w == 0) wait_us(T_TMO + 5);
    else if (d < 0) begin wait_us(w); echo_in = 1'b0; end
    else begin wait_us(d); echo_in = 1'b1; wait_us(w); echo_in = 1'b0; end
  endtask

  task automatic do_txn(input int l, input int d, input int w);
    push_txn(l, d, w);
    wait_accepts(n_exp);
    wait_us(5);
  endtask

  initial begin
    int l, d, w, m, cnt;
    repeat (3) @(posedge sys_clk);
    #1;
    check_outputs_zero("reset_state");
    sys_rst = 1'b0;
    wait_us(3);

    do_txn(50, 100, 150);          // plain measurement
    do_txn(20, 5, 0);              // no echo -> timeout
    do_txn(20, -1, T_TMO + 20);    // echo high before release -> timeout
    do_txn(15, 10, 270);           // count saturates at all-ones
    do_txn(15, 3, 1);              // shortest echo

    // Result held unaccepted; a trigger during HOLD is an overrun only.
    hold_ready = 1'b1;
    push_txn(20, 10, 40);
    cnt = 0;
    while (!result_valid && cnt < 200) begin @(posedge sys_clk); cnt++; end
    repeat (400) @(posedge sys_clk);
    #1; trig_n = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1; trig_n = 1'b1;
    ovr_exp++;
    repeat (580) @(posedge sys_clk);
    #1;
    checks++;
    if (!result_valid || busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_valid: valid=%0b busy=%0b, required 1 1", result_valid, busy);
    end
    hold_ready = 1'b0;
    wait_accepts(n_exp);
    wait_us(5);

    // Reset in the middle of a measurement discards it.
    trig_n = 1'b0; wait_us(20); trig_n = 1'b1;
    wait_us(10); echo_in = 1'b1; wait_us(50);
    @(posedge sys_clk); #3;
    sys_rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_measure");
    repeat (2) @(posedge sys_clk);
    #1; sys_rst = 1'b0; echo_in = 1'b0;
    wait_us(5);
    do_txn(30, 20, 77);

`ifdef ECHO_TIMER_TRIG_CHECK_EN
    trig_n = 1'b0; wait_us(5); trig_n = 1'b1;
    short_exp++;
    wait_us(20); echo_in = 1'b1; wait_us(30); echo_in = 1'b0;
    wait_us(T_TMO + 10);
    checks++;
    if (accepted != n_exp || result_valid) begin
      failures++;
      $display("FAIL short_no_result: accepted=%0d valid=%0b, required %0d 0", accepted, result_valid, n_exp);
    end
`else
    do_txn(5, 20, 60);
`endif

    for (int i = 0; i < 20; i++) begin
      l = $urandom_range(12, 30);
      m = $urandom_range(0, 3);
      if (m == 0) begin d = $urandom_range(1, 15); w = $urandom_range(258, 280); end
      else if (m == 1) begin d = $urandom_range(1, 40); w = $urandom_range(T_TMO + 5 - d, T_TMO + 20); end
      else begin d = $urandom_range(1, 40); w = $urandom_range(1, 200); end
      do_txn(l, d, w);
    end

    checks++;
    if (exp_q.size() != 0 || accepted != n_exp) begin
      failures++;
      $display("FAIL scoreboard_drain: left=%0d accepted=%0d, required 0 %0d", exp_q.size(), accepted, n_exp);
    end
    checks++;
    if (ovr_cnt != ovr_exp) begin
      failures++;
      $display("FAIL overrun_count: got %0d, required %0d", ovr_cnt, ovr_exp);
    end
    checks++;
    if (short_cnt != short_exp) begin
      failures++;
      $display("FAIL trig_short_count: got %0d, required %0d", short_cnt, short_exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
